// File: rtl/dbg_probe_ctrl_pkg.sv
// Shared encodings for the debug probe controller: mode codes, FREEZE states
// and the switch field positions.
package dbg_probe_ctrl_pkg;

  localparam logic [1:0] DBG_MODE_LIVE   = 2'b00;
  localparam logic [1:0] DBG_MODE_FREEZE = 2'b01;
  localparam logic [1:0] DBG_MODE_SCAN   = 2'b10;
  localparam logic [1:0] DBG_MODE_STICKY = 2'b11;

  localparam logic [0:0] FRZ_ARMED  = 1'b0;
  localparam logic [0:0] FRZ_FROZEN = 1'b1;

  localparam int unsigned SW_SEL_HI  = 15;
  localparam int unsigned SW_SEL_LO  = 8;
  localparam int unsigned SW_MODE_HI = 1;
  localparam int unsigned SW_MODE_LO = 0;
  localparam int unsigned SW_CLR     = 2;

endpackage

// File: rtl/dbg_sw_sync.sv
// Two-flop synchroniser for the board switches plus a rising-edge detector
// on the synchronised clear switch.
module dbg_sw_sync
  import dbg_probe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  output logic [15:0] sws,
  output logic        clr_pulse
);

  logic [15:0] meta_q, meta_d;
  logic [15:0] sws_q, sws_d;
  logic        clr_prev_q, clr_prev_d;

  always_comb begin
    meta_d     = sw;
    sws_d      = meta_q;
    clr_prev_d = sws_q[SW_CLR];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q     <= '0;
      sws_q      <= '0;
      clr_prev_q <= 1'b0;
    end else begin
      meta_q     <= meta_d;
      sws_q      <= sws_d;
      clr_prev_q <= clr_prev_d;
    end
  end

  assign sws       = sws_q;
  assign clr_pulse = sws_q[SW_CLR] & ~clr_prev_q;

endmodule

// File: rtl/dbg_probe_ctrl.sv
// Registered LED probe controller: live, freeze-on-trigger, auto-scan and sticky
// modes. Define DBG_PROBE_SCAN_EN to build the auto-scan mode in.
module dbg_probe_ctrl
  import dbg_probe_ctrl_pkg::*;
#(
  parameter int unsigned CH_NUM   = 64,
  parameter int unsigned CH_W     = 16,
  parameter int unsigned SCAN_DIV = 25_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              sw,
  input  logic [CH_NUM*CH_W-1:0]   probe_bus,
  input  logic                     trig,
  output logic                     frozen,
  output logic [15:0]              led_data
);

  if (CH_NUM < 1 || CH_NUM > 256) begin : g_bad_ch_num
    $error("CH_NUM must be in 1..256");
  end
  if (CH_W < 1 || CH_W > 16) begin : g_bad_ch_w
    $error("CH_W must be in 1..16");
  end
  if (SCAN_DIV < 1) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 1");
  end

  logic [15:0] sws;
  logic        clr_pulse;

  dbg_sw_sync u_sw_sync (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .sws      (sws),
    .clr_pulse(clr_pulse)
  );

  logic [7:0]  sel;
  logic [1:0]  mode;
  logic [1:0]  eff_mode;
  logic        mode_chg;
  logic        sel_chg;
  logic [15:0] lv;

  logic [1:0]  mode_q, mode_d;
  logic [7:0]  sel_q, sel_d;
  logic [0:0]  st_q, st_d, st_e;
  logic [15:0] snap_q, snap_d;
  logic [15:0] stk_q, stk_d;
  logic [15:0] led_q, led_d;

  assign sel      = sws[SW_SEL_HI:SW_SEL_LO];
  assign mode     = sws[SW_MODE_HI:SW_MODE_LO];
  assign mode_chg = (mode != mode_q);
  assign sel_chg  = (sel != sel_q);

  always_comb begin
    lv = sws;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      if (32'(sel) == k) begin
        lv             = '0;
        lv[CH_W-1:0]   = probe_bus[k*CH_W +: CH_W];
      end
    end
  end

`ifdef DBG_PROBE_SCAN_EN
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      scan_lv;

  assign eff_mode = mode;

  // Counter and index sit at zero outside SCAN, so the entry cycle already
  // shows channel 0 and counts as its first display cycle.
  always_comb begin
    cnt_d = '0;
    idx_d = '0;
    if (mode == DBG_MODE_SCAN) begin
      if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_W'(CH_NUM - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
      end
    end
  end

  always_comb begin
    scan_lv = '0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      if (32'(idx_q) == k) begin
        scan_lv[CH_W-1:0] = probe_bus[k*CH_W +: CH_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end
`else
  assign eff_mode = (mode == DBG_MODE_SCAN) ? DBG_MODE_LIVE : mode;
`endif

  always_comb begin
    mode_d = mode;
    sel_d  = sel;
    st_d   = st_q;
    snap_d = snap_q;
    stk_d  = stk_q;
    led_d  = led_q;
    st_e   = mode_chg ? FRZ_ARMED : st_q;

    case (eff_mode)
      DBG_MODE_FREEZE: begin
        if (clr_pulse) begin
          st_d  = FRZ_ARMED;
          led_d = lv;
        end else if (st_e == FRZ_ARMED) begin
          st_d  = FRZ_ARMED;
          led_d = lv;
          if (trig) begin
            snap_d = lv;
            st_d   = FRZ_FROZEN;
          end
        end else begin
          led_d = snap_q;
        end
      end
      DBG_MODE_STICKY: begin
        stk_d = ((mode_chg || clr_pulse || sel_chg) ? '0 : stk_q) | lv;
        led_d = stk_d;
      end
`ifdef DBG_PROBE_SCAN_EN
      DBG_MODE_SCAN: led_d = scan_lv;
`endif
      default: led_d = lv;
    endcase

    if (eff_mode != DBG_MODE_FREEZE) st_d = FRZ_ARMED;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= DBG_MODE_LIVE;
      sel_q  <= '0;
      st_q   <= FRZ_ARMED;
      snap_q <= '0;
      stk_q  <= '0;
      led_q  <= '0;
    end else begin
      mode_q <= mode_d;
      sel_q  <= sel_d;
      st_q   <= st_d;
      snap_q <= snap_d;
      stk_q  <= stk_d;
      led_q  <= led_d;
    end
  end

  assign led_data = led_q;
  assign frozen   = (st_q == FRZ_FROZEN);

endmodule
